// File: rtl/dma_mem_arbiter.sv
// dma_mem_arbiter: lets NUM_REQ DMA requesters share one memc port.
// The write and read channels each have their own round-robin grant pointer.
// Reads are tagged in an in-order requester-ID FIFO, so that returning data
// and the read pause are steered to the requester that issued the read.
module dma_mem_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTST_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               dma__arb__write_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    dma__arb__write_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    dma__arb__write_data,
  output logic [NUM_REQ-1:0]               arb__dma__write_ready,
  input  logic [NUM_REQ-1:0]               dma__arb__read_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    dma__arb__read_address,
  output logic [NUM_REQ-1:0]               arb__dma__read_ready,
  output logic [DATA_WIDTH-1:0]            arb__dma__read_data,
  output logic [NUM_REQ-1:0]               arb__dma__read_data_valid,
  input  logic [NUM_REQ-1:0]               dma__arb__read_pause,
  output logic                             arb__memc__write_valid,
  output logic [ADDR_WIDTH-1:0]            arb__memc__write_address,
  output logic [DATA_WIDTH-1:0]            arb__memc__write_data,
  input  logic                             memc__arb__write_ready,
  output logic                             arb__memc__read_valid,
  output logic [ADDR_WIDTH-1:0]            arb__memc__read_address,
  input  logic                             memc__arb__read_ready,
  input  logic [DATA_WIDTH-1:0]            memc__arb__read_data,
  input  logic                             memc__arb__read_data_valid,
  output logic                             arb__memc__read_pause,
  output logic                             arb__sys__error
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int CW  = $clog2(OUTST_DEPTH + 1);

  typedef logic [IDW-1:0] id_t;

  // Next requester index, wrapping modulo NUM_REQ (NUM_REQ need not be a power of 2).
  function automatic id_t next_id(input id_t i);
    return (i == id_t'(NUM_REQ - 1)) ? id_t'(0) : id_t'(i + 1'b1);
  endfunction

  // First requester with valid set, scanning from ptr and wrapping around.
  function automatic id_t pick(input logic [NUM_REQ-1:0] vld, input id_t ptr);
    id_t  idx;
    id_t  gnt;
    logic found;
    idx   = ptr;
    gnt   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && vld[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
      idx = next_id(idx);
    end
    return gnt;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input id_t i);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  id_t              wr_ptr;
  id_t              rd_ptr;
  id_t              wr_gnt;
  id_t              rd_gnt;
  logic             wr_any;
  logic             wr_acc;
  logic             rd_any;
  logic             rd_acc;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             err_set;
  logic             err_q;
  id_t              fifo_mem [OUTST_DEPTH];
  logic [PW-1:0]    fifo_wr_idx;
  logic [PW-1:0]    fifo_rd_idx;
  logic [CW-1:0]    fifo_cnt;
  id_t              head_id;

  // ---------------- write channel ----------------
  assign wr_gnt = pick(dma__arb__write_valid, wr_ptr);
  assign wr_any = reset & (|dma__arb__write_valid);
  assign wr_acc = wr_any & memc__arb__write_ready;

  assign arb__memc__write_valid   = wr_any;
  assign arb__memc__write_address = reset ?
      dma__arb__write_address[int'(wr_gnt)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign arb__memc__write_data    = reset ?
      dma__arb__write_data[int'(wr_gnt)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign arb__dma__write_ready    = wr_acc ? onehot(wr_gnt) : '0;

  // ---------------- read request channel ----------------
  // A full ID FIFO blocks new reads even if a return frees a slot this cycle.
  assign fifo_full  = (fifo_cnt == CW'(OUTST_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign rd_gnt = pick(dma__arb__read_valid, rd_ptr);
  assign rd_any = reset & (|dma__arb__read_valid) & ~fifo_full;
  assign rd_acc = rd_any & memc__arb__read_ready;

  assign arb__memc__read_valid   = rd_any;
  assign arb__memc__read_address = reset ?
      dma__arb__read_address[int'(rd_gnt)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign arb__dma__read_ready    = rd_acc ? onehot(rd_gnt) : '0;

  // ---------------- read return channel ----------------
  assign head_id  = fifo_mem[fifo_rd_idx];
  assign fifo_pop = reset & memc__arb__read_data_valid & ~fifo_empty;
  assign err_set  = reset & memc__arb__read_data_valid & fifo_empty;

  assign arb__dma__read_data       = reset ? memc__arb__read_data : '0;
  assign arb__dma__read_data_valid = fifo_pop ? onehot(head_id) : '0;
  assign arb__memc__read_pause     = reset & ~fifo_empty & dma__arb__read_pause[head_id];
  assign arb__sys__error           = err_q;

  // Grant pointers, FIFO bookkeeping and the sticky error flag.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_wr_idx <= '0;
      fifo_rd_idx <= '0;
      fifo_cnt    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= next_id(wr_gnt);
      if (rd_acc) begin
        rd_ptr      <= next_id(rd_gnt);
        fifo_wr_idx <= fifo_wr_idx + 1'b1;
      end
      if (fifo_pop) fifo_rd_idx <= fifo_rd_idx + 1'b1;
      case ({rd_acc, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (err_set) err_q <= 1'b1;
    end
  end

  // ID FIFO storage: records which requester issued each outstanding read.
  // NOTE: the storage array is deliberately not reset; validity is tracked by fifo_cnt alone.
  always_ff @(posedge clk) begin
    if (rd_acc) fifo_mem[fifo_wr_idx] <= rd_gnt;
  end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Self-checking bench for dma_mem_arbiter: a directed vector table,
// hand-written sequences for the multi-cycle corner cases, and a randomized
// phase compared against a queue-based reference model.
module tb_dma_mem_arbiter;

  localparam int N     = 2;
  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    wv;
  logic [N*AW-1:0] waddr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    wrdy;
  logic [N-1:0]    rv;
  logic [N*AW-1:0] raddr;
  logic [N-1:0]    rrdy;
  logic [DW-1:0]   rdata;
  logic [N-1:0]    rdv;
  logic [N-1:0]    pause;
  logic            m_wv;
  logic [AW-1:0]   m_waddr;
  logic [DW-1:0]   m_wdata;
  logic            mwr;
  logic            m_rv;
  logic [AW-1:0]   m_raddr;
  logic            mrr;
  logic [DW-1:0]   mdata;
  logic            mdv;
  logic            m_pause;
  logic            err;

  int n_checks = 0;
  int n_pass   = 0;

  dma_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTST_DEPTH(DEPTH)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .dma__arb__write_valid      (wv),
    .dma__arb__write_address    (waddr),
    .dma__arb__write_data       (wdata),
    .arb__dma__write_ready      (wrdy),
    .dma__arb__read_valid       (rv),
    .dma__arb__read_address     (raddr),
    .arb__dma__read_ready       (rrdy),
    .arb__dma__read_data        (rdata),
    .arb__dma__read_data_valid  (rdv),
    .dma__arb__read_pause       (pause),
    .arb__memc__write_valid     (m_wv),
    .arb__memc__write_address   (m_waddr),
    .arb__memc__write_data      (m_wdata),
    .memc__arb__write_ready     (mwr),
    .arb__memc__read_valid      (m_rv),
    .arb__memc__read_address    (m_raddr),
    .memc__arb__read_ready      (mrr),
    .memc__arb__read_data       (mdata),
    .memc__arb__read_data_valid (mdv),
    .arb__memc__read_pause      (m_pause),
    .arb__sys__error            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wv = '0; rv = '0; mwr = 1'b0; mrr = 1'b0; mdv = 1'b0; mdata = '0; pause = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0]  wv;
    logic          mwr;
    logic [N-1:0]  rv;
    logic          mrr;
    logic [N-1:0]  exp_wrdy;
    logic          exp_mwv;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    logic [N-1:0]  exp_rrdy;
    logic          exp_mrv;
    logic [AW-1:0] exp_raddr;
  } vec_t;

  vec_t tbl [9];

  // ---------------- reference model ----------------
  int ref_wr_ptr;
  int ref_rd_ptr;
  int ref_q [$];
  bit ref_err;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // One cycle: compare all outputs at the falling edge, advance the model at the rising edge.
  task automatic model_cycle();
    int gw, gr;
    bit wacc, racc, pop, erow;
    logic [N-1:0] exp_rdv;
    @(negedge clk);
    gw   = pick(wv, ref_wr_ptr);
    wacc = (gw >= 0) && mwr;
    check("rnd_mwv", m_wv, (gw >= 0));
    check("rnd_wrdy", wrdy, wacc ? oh(gw) : '0);
    if (gw >= 0) begin
      check("rnd_waddr", m_waddr, waddr[gw*AW +: AW]);
      check("rnd_wdata", m_wdata, wdata[gw*DW +: DW]);
    end
    gr   = pick(rv, ref_rd_ptr);
    racc = (gr >= 0) && (ref_q.size() < DEPTH) && mrr;
    check("rnd_mrv", m_rv, (gr >= 0) && (ref_q.size() < DEPTH));
    check("rnd_rrdy", rrdy, racc ? oh(gr) : '0);
    if (gr >= 0 && ref_q.size() < DEPTH) check("rnd_raddr", m_raddr, raddr[gr*AW +: AW]);
    pop     = mdv && (ref_q.size() > 0);
    erow    = mdv && (ref_q.size() == 0);
    exp_rdv = pop ? oh(ref_q[0]) : '0;
    check("rnd_rdv", rdv, exp_rdv);
    check("rnd_rdata", rdata, mdata);
    check("rnd_pause", m_pause, (ref_q.size() > 0) ? pause[ref_q[0]] : 1'b0);
    check("rnd_err", err, ref_err);
    @(posedge clk);
    if (wacc) ref_wr_ptr = (gw + 1) % N;
    if (pop) void'(ref_q.pop_front());
    if (erow) ref_err = 1'b1;
    if (racc) begin
      ref_q.push_back(gr);
      ref_rd_ptr = (gr + 1) % N;
    end
    #1;
  endtask

  initial begin
    tbl[0] = '{2'b11, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 24'h100, 32'hAAAA0000, 2'b01, 1'b1, 24'h200};
    tbl[1] = '{2'b11, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 24'h101, 32'hBBBB0001, 2'b10, 1'b1, 24'h201};
    tbl[2] = '{2'b11, 1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 24'h100, 32'hAAAA0000, 2'b00, 1'b1, 24'h200};
    tbl[3] = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 24'h101, 32'hBBBB0001, 2'b01, 1'b1, 24'h200};
    tbl[4] = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 24'h100, 32'hAAAA0000, 2'b00, 1'b0, 24'h000};
    tbl[5] = '{2'b10, 1'b1, 2'b00, 1'b0, 2'b10, 1'b1, 24'h101, 32'hBBBB0001, 2'b00, 1'b0, 24'h000};
    tbl[6] = '{2'b11, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 24'h100, 32'hAAAA0000, 2'b00, 1'b0, 24'h000};
    tbl[7] = '{2'b01, 1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 24'h100, 32'hAAAA0000, 2'b00, 1'b0, 24'h000};
    tbl[8] = '{2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 24'h000, 32'h00000000, 2'b00, 1'b0, 24'h000};

    // ---- reset state: outputs gated even with requests asserted ----
    reset = 1'b0;
    waddr = {24'h000101, 24'h000100};
    wdata = {32'hBBBB0001, 32'hAAAA0000};
    raddr = {24'h000201, 24'h000200};
    wv = 2'b11; rv = 2'b11; mwr = 1'b1; mrr = 1'b1; mdv = 1'b1; mdata = 32'h12345678; pause = 2'b11;
    #12;
    check("rst_mwv", m_wv, 1'b0);
    check("rst_mrv", m_rv, 1'b0);
    check("rst_wrdy", wrdy, 2'b00);
    check("rst_rrdy", rrdy, 2'b00);
    check("rst_rdv", rdv, 2'b00);
    check("rst_pause", m_pause, 1'b0);
    check("rst_waddr", m_waddr, 24'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", err, 1'b0);
    idle_inputs();
    #10 reset = 1'b1;
    tick();

    // ---- table: write alternation, stall holds pointer, independent read channel ----
    for (int i = 0; i < 9; i++) begin
      wv = tbl[i].wv; mwr = tbl[i].mwr; rv = tbl[i].rv; mrr = tbl[i].mrr;
      @(negedge clk);
      check($sformatf("tbl%0d_wrdy", i), wrdy, tbl[i].exp_wrdy);
      check($sformatf("tbl%0d_mwv", i), m_wv, tbl[i].exp_mwv);
      if (tbl[i].exp_mwv) begin
        check($sformatf("tbl%0d_waddr", i), m_waddr, tbl[i].exp_waddr);
        check($sformatf("tbl%0d_wdata", i), m_wdata, tbl[i].exp_wdata);
      end
      check($sformatf("tbl%0d_rrdy", i), rrdy, tbl[i].exp_rrdy);
      check($sformatf("tbl%0d_mrv", i), m_rv, tbl[i].exp_mrv);
      if (tbl[i].exp_mrv) check($sformatf("tbl%0d_raddr", i), m_raddr, tbl[i].exp_raddr);
      tick();
    end
    idle_inputs();

    // ---- in-order returns (issued 0,1,0) and pause steering ----
    pause = 2'b10;
    @(negedge clk);
    check("pause_nonhead", m_pause, 1'b0);
    mdv = 1'b1; mdata = 32'h11111111;
    #1;
    check("ret0_rdv", rdv, 2'b01);
    check("ret0_data", rdata, 32'h11111111);
    tick();
    mdv = 1'b0;
    @(negedge clk);
    check("pause_head1", m_pause, 1'b1);
    pause = 2'b01;
    #1;
    check("pause_head1_other", m_pause, 1'b0);
    tick();
    mdv = 1'b1; mdata = 32'h22222222;
    @(negedge clk);
    check("ret1_rdv", rdv, 2'b10);
    check("ret1_data", rdata, 32'h22222222);
    tick();
    mdata = 32'h33333333;
    @(negedge clk);
    check("ret2_rdv", rdv, 2'b01);
    tick();
    mdv = 1'b0; pause = 2'b11;
    @(negedge clk);
    check("pause_empty", m_pause, 1'b0);
    check("no_err_yet", err, 1'b0);
    tick();
    idle_inputs();

    // ---- stalled read from req1 ----
    raddr = {24'h000010, 24'h000200};
    rv = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rrdy", rrdy, 2'b00);
      check("stall_mrv", m_rv, 1'b1);
      check("stall_raddr", m_raddr, 24'h000010);
      tick();
    end
    mrr = 1'b1;
    @(negedge clk);
    check("stall_accept", rrdy, 2'b10);
    tick();
    rv = 2'b11; mrr = 1'b0; mdv = 1'b1; mdata = 32'hDEADBEEF;
    @(negedge clk);
    check("beef_rdv", rdv, 2'b10);
    check("beef_data", rdata, 32'hDEADBEEF);
    check("ptr_after_req1", m_raddr, 24'h000200);
    tick();
    idle_inputs();

    // ---- fill the ID FIFO, no bypass on the freeing cycle ----
    rv = 2'b01; mrr = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check($sformatf("fill%0d_rrdy", i), rrdy, 2'b01);
      tick();
    end
    @(negedge clk);
    check("full_mrv", m_rv, 1'b0);
    check("full_rrdy", rrdy, 2'b00);
    tick();
    mdv = 1'b1; mdata = 32'h44444444;
    @(negedge clk);
    check("full_pop_rdv", rdv, 2'b01);
    check("full_nobypass", rrdy, 2'b00);
    tick();
    mdv = 1'b0;
    @(negedge clk);
    check("freed_accept", rrdy, 2'b01);
    tick();
    rv = 2'b00; mdv = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d_rdv", i), rdv, 2'b01);
      tick();
    end
    idle_inputs();

    // ---- empty pop sets sticky error; async reset clears everything ----
    mdv = 1'b1;
    @(negedge clk);
    check("emptypop_rdv", rdv, 2'b00);
    tick();
    mdv = 1'b0;
    check("err_set", err, 1'b1);
    tick();
    tick();
    check("err_sticky", err, 1'b1);
    rv = 2'b11; mrr = 1'b1;
    tick();
    tick();
    wv = 2'b11; mwr = 1'b1; mdv = 1'b1; pause = 2'b11;
    #2 reset = 1'b0;
    #1;
    check("arst_err", err, 1'b0);
    check("arst_mwv", m_wv, 1'b0);
    check("arst_mrv", m_rv, 1'b0);
    check("arst_wrdy", wrdy, 2'b00);
    check("arst_rrdy", rrdy, 2'b00);
    check("arst_rdv", rdv, 2'b00);
    check("arst_pause", m_pause, 1'b0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    pause = 2'b11;
    #1;
    check("post_rst_pause", m_pause, 1'b0);
    mdv = 1'b1;
    #1;
    check("stale_ret_rdv", rdv, 2'b00);
    tick();
    check("stale_ret_err", err, 1'b1);
    idle_inputs();

    // ---- randomized phase against the reference model ----
    #3 reset = 1'b0;
    #3 reset = 1'b1;
    ref_wr_ptr = 0; ref_rd_ptr = 0; ref_q.delete(); ref_err = 1'b0;
    tick();
    for (int c = 0; c < 600; c++) begin
      wv    = N'($urandom);
      rv    = N'($urandom);
      mwr   = ($urandom_range(0, 3) != 0);
      mrr   = ($urandom_range(0, 3) != 0);
      mdv   = ($urandom_range(0, 2) == 0);
      mdata = $urandom;
      pause = N'($urandom);
      for (int k = 0; k < N; k++) begin
        waddr[k*AW +: AW] = AW'($urandom);
        raddr[k*AW +: AW] = AW'($urandom);
        wdata[k*DW +: DW] = $urandom;
      end
      model_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
